coeff_buffer_reader: RTL

//   Read-side controller for the two-bank coefficient buffer. It drains one

---
 rtl/coeff_buffer_reader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/coeff_buffer_reader.sv
// ============================================================================
//  Module   : coeff_buffer_reader
//  Purpose  : Read-side controller for the two-bank coefficient buffer.
//             Drains one macroblock of packed coefficient pairs from the
//             filled bank through a 1-cycle-latency read port, streams them
//             over valid/ready through a 2-entry output FIFO, then releases
//             the bank back to the writer. Banks alternate starting at 0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module coeff_buffer_reader #(
    parameter int ADDR_WIDTH      = 11,
    parameter int WORDS_PER_BLOCK = 32,
    parameter int BLOCKS_PER_BANK = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Bank_Ready_I,
    output logic [1:0]            Bank_Release_O,
    output logic                  Enable_B_O,
    output logic [ADDR_WIDTH-1:0] Address_B_O,
    input  logic [31:0]           Data_B_I,
    output logic [31:0]           Coeff_Data_O,
    output logic                  Coeff_Valid_O,
    input  logic                  Coeff_Ready_I,
    output logic                  Block_Start_O,
    output logic                  Busy_O
);

    localparam int c_OFF_W = ADDR_WIDTH - 1;
    localparam int c_TOTAL = WORDS_PER_BLOCK * BLOCKS_PER_BANK;
    localparam int c_BLK_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [c_OFF_W-1:0] c_LAST_OFF = c_OFF_W'(c_TOTAL - 1);
    localparam logic [c_BLK_W-1:0] c_LAST_BLK = c_BLK_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               state_q;
    logic                 cur_bank_q;
    logic [c_OFF_W-1:0]   offset_q;
    logic [c_BLK_W-1:0]   blk_word_q;     // offset modulo WORDS_PER_BLOCK, tracked incrementally
    logic                 inflight_q;     // a read was issued last cycle; Data_B_I is valid now
    logic                 inflight_sof_q; // that read was the first word of a block

    // Two-entry FIFO held as head/tail registers; head drives the outputs directly
    logic                 head_vld_q, head_vld_d;
    logic                 head_sof_q, head_sof_d;
    logic [31:0]          head_data_q, head_data_d;
    logic                 tail_vld_q, tail_vld_d;
    logic                 tail_sof_q, tail_sof_d;
    logic [31:0]          tail_data_q, tail_data_d;

    logic                 w_pop;
    logic                 w_push;
    logic [1:0]           w_occ;
    logic                 w_issue;
    logic                 w_overflow;

    assign w_pop   = head_vld_q & Coeff_Ready_I;
    assign w_push  = inflight_q;
    // Occupancy the FIFO will see once every outstanding read has landed,
    // net of the word leaving this cycle; pop implies head valid, so no underflow.
    assign w_occ   = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, inflight_q}
                   - {1'b0, w_pop};
    assign w_issue = (state_q == S_READ) && (w_occ < 2'd2);
    assign w_overflow = w_push && head_vld_q && tail_vld_q && !w_pop;

    assign Enable_B_O     = w_issue;
    assign Address_B_O    = {cur_bank_q, offset_q};
    assign Bank_Release_O = (state_q == S_RELEASE) ? (cur_bank_q ? 2'b10 : 2'b01) : 2'b00;
    assign Busy_O         = (state_q != S_IDLE);
    assign Coeff_Data_O   = head_data_q;
    assign Coeff_Valid_O  = head_vld_q;
    assign Block_Start_O  = head_sof_q;

    // Control FSM: bank alternation, read address sequencing and drain/release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cur_bank_q     <= 1'b0;
            offset_q       <= '0;
            blk_word_q     <= '0;
            inflight_q     <= 1'b0;
            inflight_sof_q <= 1'b0;
        end else begin
            inflight_q <= w_issue;
            if (w_issue) begin
                inflight_sof_q <= (blk_word_q == '0);
            end
            case (state_q)
                S_IDLE: begin
                    if (Bank_Ready_I[cur_bank_q]) begin
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        if (offset_q == c_LAST_OFF) begin
                            offset_q   <= '0;
                            blk_word_q <= '0;
                            state_q    <= S_DRAIN;
                        end else begin
                            offset_q   <= offset_q + c_OFF_W'(1);
                            blk_word_q <= (blk_word_q == c_LAST_BLK) ? '0
                                                                     : blk_word_q + c_BLK_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!head_vld_q && !tail_vld_q && !inflight_q) begin
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    cur_bank_q <= ~cur_bank_q;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO next state: pop shifts tail into head, push fills the first free slot
    always_comb begin
        head_vld_d  = head_vld_q;
        head_sof_d  = head_sof_q;
        head_data_d = head_data_q;
        tail_vld_d  = tail_vld_q;
        tail_sof_d  = tail_sof_q;
        tail_data_d = tail_data_q;
        if (w_pop) begin
            head_vld_d  = tail_vld_q;
            head_sof_d  = tail_sof_q;
            head_data_d = tail_data_q;
            tail_vld_d  = 1'b0;
        end
        if (w_push) begin
            if (!head_vld_d) begin
                head_vld_d  = 1'b1;
                head_sof_d  = inflight_sof_q;
                head_data_d = Data_B_I;
            end else begin
                tail_vld_d  = 1'b1;
                tail_sof_d  = inflight_sof_q;
                tail_data_d = Data_B_I;
            end
        end
    end

    // FIFO storage registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_vld_q  <= 1'b0;
            head_sof_q  <= 1'b0;
            head_data_q <= '0;
            tail_vld_q  <= 1'b0;
            tail_sof_q  <= 1'b0;
            tail_data_q <= '0;
        end else begin
            head_vld_q  <= head_vld_d;
            head_sof_q  <= head_sof_d;
            head_data_q <= head_data_d;
            tail_vld_q  <= tail_vld_d;
            tail_sof_q  <= tail_sof_d;
            tail_data_q <= tail_data_d;
        end
    end

`ifndef SYNTHESIS
    // The issue throttle guarantees a landing slot for every outstanding read
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!w_overflow);
        end
    end
`endif

endmodule

`default_nettype wire
